// File: rtl/mips_program_loader.sv
// mips_program_loader: streams a length-prefixed, XOR-checksummed byte image into instruction memory and releases the core on success.
// Define LOADER_TIMEOUT_EN to abort a stalled load after TIMEOUT_CYCLES idle cycles (error code 11).
module mips_program_loader #(
    parameter int ADDR_WIDTH     = 10,
    parameter int BASE_ADDR      = 0,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clock_1,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            error_code,
    output logic                  core_release,
    output logic [ADDR_WIDTH:0]   word_count
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [31:0] LIMIT = (32'd1 << ADDR_WIDTH) - 32'(BASE_ADDR);

    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR} state_t;

    state_t          state, state_next;
    logic [1:0]      code_next;
    logic [7:0]      len_hi, acc;
    logic [23:0]     word;
    logic [1:0]      byte_cnt;
    logic [CW-1:0]   len;
    logic [15:0]     n;
    logic            xfer, word_end, last_word, overflow, timeout;

    assign byte_ready   = state inside {LEN_HI, LEN_LO, DATA, CHECK};
    assign busy         = byte_ready;
    assign done         = state == DONE;
    assign core_release = done;
    assign error        = state == ERROR;
    assign xfer         = byte_valid && byte_ready;
    assign n            = {len_hi, byte_in};
    assign overflow     = 32'(n) > LIMIT;
    assign last_word    = word_count + CW'(1) == len;
    assign word_end     = state == DATA && xfer && byte_cnt == 2'd3 && !timeout;

`ifdef LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;
    assign timeout = byte_ready && 32'(idle_cnt) == 32'(TIMEOUT_CYCLES);
    always_ff @(posedge clock_1) begin
        if (!reset_n || xfer || !byte_ready)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + TW'(1);
    end
`else
    assign timeout = TIMEOUT_CYCLES < 0;
`endif

    always_ff @(posedge clock_1) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        code_next  = error_code;
        case (state)
            IDLE:   if (start) state_next = LEN_HI;
            LEN_HI: if (xfer) state_next = LEN_LO;
            LEN_LO: if (xfer) begin
                if (overflow) begin
                    state_next = ERROR;
                    code_next  = 2'b01;
                end else
                    state_next = n == 16'd0 ? CHECK : DATA;
            end
            DATA:   if (word_end && last_word) state_next = CHECK;
            CHECK:  if (xfer) begin
                state_next = byte_in == acc ? DONE : ERROR;
                code_next  = byte_in == acc ? 2'b00 : 2'b10;
            end
            default: if (start) begin
                state_next = LEN_HI;
                code_next  = 2'b00;
            end
        endcase
        if (timeout) begin
            state_next = ERROR;
            code_next  = 2'b11;
        end
    end

    always_ff @(posedge clock_1) begin
        if (!reset_n) begin
            error_code <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
            acc        <= '0;
            len_hi     <= '0;
            len        <= '0;
            word       <= '0;
            byte_cnt   <= '0;
        end else begin
            error_code <= code_next;
            mem_we     <= word_end;
            // start is only honoured while not streaming, i.e. exactly when byte_ready is low
            if (start && !byte_ready) begin
                acc        <= '0;
                word_count <= '0;
                byte_cnt   <= '0;
            end else if (xfer) begin
                if (state != CHECK) acc <= acc ^ byte_in;
                if (state == LEN_HI) len_hi <= byte_in;
                if (state == LEN_LO) len <= CW'(n);
                if (state == DATA) begin
                    byte_cnt <= byte_cnt + 2'd1;
                    word     <= {word[15:0], byte_in};
                end
            end
            if (word_end) begin
                mem_addr   <= ADDR_WIDTH'(BASE_ADDR) + word_count[ADDR_WIDTH-1:0];
                mem_wdata  <= {word, byte_in};
                word_count <= word_count + CW'(1);
            end
        end
    end
endmodule
